// File: rtl/wrapper_ahb_packet_fifo_constructor.sv
// AHB-lite target that assembles 32-bit writes into PACKETWIDTH-bit packets and streams them from a FIFO.
// Optional status register: define WRAPPER_PKT_STATUS_EN.
module wrapper_ahb_packet_fifo_constructor #(
   parameter int ADDRWIDTH   = 11,
   parameter int PACKETWIDTH = 512,
   parameter int FIFODEPTH   = 2
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic                   HSELS,
   input  logic [ADDRWIDTH-1:0]   HADDRS,
   input  logic [1:0]             HTRANSS,
   input  logic [2:0]             HSIZES,
   input  logic                   HWRITES,
   input  logic                   HREADYS,
   input  logic [31:0]            HWDATAS,
   output logic                   HREADYOUTS,
   output logic                   HRESPS,
   output logic [31:0]            HRDATAS,
   output logic [PACKETWIDTH-1:0] packet_data,
   output logic                   packet_data_last,
   output logic                   packet_data_valid,
   input  logic                   packet_data_ready,
   output logic                   data_req
);
   localparam int WORDS = PACKETWIDTH / 32;
   localparam int IW    = $clog2(WORDS);
   localparam int PW    = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
   localparam int CW    = $clog2(FIFODEPTH + 1);

   // Stream handshake: a packet transfers on a cycle where packet_data_valid and
   // packet_data_ready are both high; valid never depends on ready.
   logic                   dp_write, dp_read, dp_last;
   logic [IW-1:0]          dp_idx;
   logic [3:0]             dp_be, ap_be;
   logic [31:0]            stage [WORDS];
   logic [PACKETWIDTH-1:0] mem [FIFODEPTH];
   logic [FIFODEPTH-1:0]   mem_last;
   logic [PW-1:0]          rd_ptr, wr_ptr;
   logic [CW-1:0]          count;
   logic                   full, pop, complete, push, wr_ok, idx_ok;
   logic [31:0]            cur_word, wr_word;
   logic [PACKETWIDTH-1:0] push_pkt;
   logic                   unused_ok;

   assign unused_ok = ^{HADDRS, HTRANSS[0], HSIZES[2]};

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(FIFODEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      ap_be = 4'b1111;
      case (HSIZES[1:0])
         2'b00:   ap_be = 4'b0001 << HADDRS[1:0];
         2'b01:   ap_be = HADDRS[1] ? 4'b1100 : 4'b0011;
         default: ap_be = 4'b1111;
      endcase
   end

`ifdef WRAPPER_PKT_STATUS_EN
   logic             dp_status;
   logic [WORDS-1:0] written;
   logic [7:0]       wcnt;
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_write <= 1'b0;
         dp_read  <= 1'b0;
         dp_last  <= 1'b0;
         dp_idx   <= '0;
         dp_be    <= '0;
`ifdef WRAPPER_PKT_STATUS_EN
         dp_status <= 1'b0;
`endif
      end else if (HREADYS) begin
         dp_write <= HSELS & HTRANSS[1] & HWRITES;
         dp_read  <= HSELS & HTRANSS[1] & ~HWRITES;
         dp_last  <= HADDRS[ADDRWIDTH-1];
         dp_idx   <= HADDRS[IW+1:2];
         dp_be    <= ap_be;
`ifdef WRAPPER_PKT_STATUS_EN
         dp_status <= HADDRS[ADDRWIDTH-2];
`endif
      end
   end

   // Only the completing word of a packet can stall, and only if no slot frees this cycle.
   always_comb begin
      full       = (count == CW'(FIFODEPTH));
      pop        = (count != '0) & packet_data_ready;
      idx_ok     = ({1'b0, dp_idx} < (IW + 1)'(WORDS));
      complete   = dp_write & (dp_idx == IW'(WORDS - 1));
      HREADYOUTS = ~(complete & full & ~pop);
      wr_ok      = dp_write & HREADYOUTS & idx_ok;
      push       = complete & HREADYOUTS;
      cur_word   = idx_ok ? stage[dp_idx] : '0;
      for (int b = 0; b < 4; b++)
         wr_word[8*b +: 8] = dp_be[b] ? HWDATAS[8*b +: 8] : cur_word[8*b +: 8];
      for (int i = 0; i < WORDS; i++)
         push_pkt[32*i +: 32] = (i == WORDS - 1) ? wr_word : stage[i];
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < WORDS; i++) stage[i] <= '0;
      end else if (push) begin
         for (int i = 0; i < WORDS; i++) stage[i] <= '0;
      end else if (wr_ok) begin
         stage[dp_idx] <= wr_word;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         mem_last <= '0;
         for (int i = 0; i < FIFODEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr]      <= push_pkt;
            mem_last[wr_ptr] <= dp_last;
            wr_ptr           <= ptr_next(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_next(rd_ptr);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   assign packet_data       = mem[rd_ptr];
   assign packet_data_last  = mem_last[rd_ptr];
   assign packet_data_valid = (count != '0);
   assign data_req          = (count < CW'(FIFODEPTH));
   assign HRESPS            = 1'b0;

`ifdef WRAPPER_PKT_STATUS_EN
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)    written <= '0;
      else if (push)   written <= '0;
      else if (wr_ok)  written[dp_idx] <= 1'b1;
   end

   always_comb begin
      wcnt = '0;
      for (int i = 0; i < WORDS; i++) wcnt = wcnt + 8'(written[i]);
   end

   always_comb begin
      HRDATAS = '0;
      if (dp_read && dp_status)   HRDATAS = {16'b0, 8'(count), wcnt};
      else if (dp_read && idx_ok) HRDATAS = stage[dp_idx];
   end
`else
   always_comb begin
      HRDATAS = '0;
      if (dp_read && idx_ok) HRDATAS = stage[dp_idx];
   end
`endif
endmodule

// File: tb/tb_wrapper_ahb_packet_fifo_constructor.sv
// Bench for wrapper_ahb_packet_fifo_constructor: AHB writes scored against a byte-level packet model.
// Status register scenario included when WRAPPER_PKT_STATUS_EN is defined.
`timescale 1ns/1ps
module tb_wrapper_ahb_packet_fifo_constructor;
   localparam int PW    = 512;
   localparam int WORDS = 16;

   logic          HCLK = 1'b0, HRESETn = 1'b0, HSELS = 1'b0, HWRITES = 1'b0;
   logic [10:0]   HADDRS = '0;
   logic [1:0]    HTRANSS = '0;
   logic [2:0]    HSIZES = 3'd2;
   logic [31:0]   HWDATAS = '0;
   logic          HREADYS, HREADYOUTS, HRESPS;
   logic [31:0]   HRDATAS;
   logic [PW-1:0] packet_data;
   logic          packet_data_last, packet_data_valid, data_req;
   logic          packet_data_ready = 1'b0;

   assign HREADYS = HREADYOUTS;

   wrapper_ahb_packet_fifo_constructor dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
      .HSIZES(HSIZES), .HWRITES(HWRITES), .HREADYS(HREADYS), .HWDATAS(HWDATAS),
      .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .HRDATAS(HRDATAS),
      .packet_data(packet_data), .packet_data_last(packet_data_last),
      .packet_data_valid(packet_data_valid), .packet_data_ready(packet_data_ready),
      .data_req(data_req)
   );

   always #5 HCLK = ~HCLK;

   // Reference model: byte image of the staging packet and a queue of {last, packet}.
   logic [7:0]       m_stage [WORDS*4];
   logic [WORDS-1:0] m_written;
   logic [PW:0]      exp_q[$];
   logic [PW:0]      mon_exp;
   logic [PW-1:0]    last_beat_data;
   logic             last_beat_last;
   logic             mon_en = 1'b0, rnd_ready = 1'b0;
   int               n_checks = 0, n_pass = 0, beats = 0;

   function automatic void model_clear();
      for (int i = 0; i < WORDS*4; i++) m_stage[i] = 8'h00;
      m_written = '0;
   endfunction

   function automatic logic [31:0] model_word(input int idx);
      return {m_stage[idx*4+3], m_stage[idx*4+2], m_stage[idx*4+1], m_stage[idx*4]};
   endfunction

   function automatic void model_write(input logic [10:0] addr, input logic [31:0] data, input logic [2:0] size);
      int idx, base, nb;
      logic [PW-1:0] pkt;
      idx  = int'(addr[5:2]);
      nb   = 1 << size;
      base = int'(addr[1:0]) & ~(nb - 1);
      for (int b = base; b < base + nb; b++) m_stage[idx*4+b] = data[8*b +: 8];
      m_written[idx] = 1'b1;
      if (idx == WORDS - 1) begin
         for (int i = 0; i < WORDS*4; i++) pkt[8*i +: 8] = m_stage[i];
         exp_q.push_back({addr[10], pkt});
         model_clear();
      end
   endfunction

   // Scoreboard: every accepted beat must match the oldest expected packet.
   always @(negedge HCLK) begin
      if (mon_en && HRESETn && packet_data_valid && packet_data_ready) begin
         beats++;
         last_beat_data = packet_data;
         last_beat_last = packet_data_last;
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL beat_unexpected: got beat word0=%h, required no beat", packet_data[31:0]);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({packet_data_last, packet_data} !== mon_exp)
               $display("FAIL beat_data: got last=%b data=%h, required last=%b data=%h",
                        packet_data_last, packet_data, mon_exp[PW], mon_exp[PW-1:0]);
            else n_pass++;
         end
      end
   end

   always @(posedge HCLK) begin
      if (rnd_ready) begin
         #1;
         packet_data_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic step();
      @(posedge HCLK); #1;
   endtask

   task automatic ahb_write(input logic [10:0] addr, input logic [31:0] data, input logic [2:0] size, output int stalls);
      bit done;
      done = 1'b0;
      stalls = 0;
      HSELS = 1'b1; HTRANSS = 2'b10; HWRITES = 1'b1; HADDRS = addr; HSIZES = size;
      step();
      HSELS = 1'b0; HTRANSS = 2'b00; HWRITES = 1'b0; HWDATAS = data;
      for (int c = 0; c < 200; c++) begin
         @(negedge HCLK);
         if (HREADYOUTS) begin done = 1'b1; break; end
         stalls++;
      end
      if (!done) begin
         n_checks++;
         $display("FAIL write_timeout: addr=%h still stalled after 200 cycles, required completion", addr);
      end else model_write(addr, data, size);
      step();
   endtask

   task automatic ahb_read(input logic [10:0] addr, output logic [31:0] data);
      HSELS = 1'b1; HTRANSS = 2'b10; HWRITES = 1'b0; HADDRS = addr; HSIZES = 3'd2;
      step();
      HSELS = 1'b0; HTRANSS = 2'b00;
      data = HRDATAS;
      step();
   endtask

   task automatic write_packet(input logic last, output int stalls);
      int st;
      stalls = 0;
      for (int i = 0; i < WORDS; i++) begin
         ahb_write(11'((int'(last) << 10) | (i * 4)), $urandom, 3'd2, st);
         stalls += st;
      end
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      model_clear();
      repeat (3) step();
      HRESETn = 1'b1;
      #1;
      n_checks++; if (HREADYOUTS !== 1'b1) $display("FAIL reset_hreadyout: got %b, required 1", HREADYOUTS); else n_pass++;
      n_checks++; if (HRESPS !== 1'b0) $display("FAIL reset_hresp: got %b, required 0", HRESPS); else n_pass++;
      n_checks++; if (HRDATAS !== 32'h0) $display("FAIL reset_hrdata: got %h, required 0", HRDATAS); else n_pass++;
      n_checks++; if (packet_data_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", packet_data_valid); else n_pass++;
      n_checks++; if (packet_data_last !== 1'b0) $display("FAIL reset_last: got %b, required 0", packet_data_last); else n_pass++;
      n_checks++; if (packet_data !== '0) $display("FAIL reset_data: got %h, required 0", packet_data); else n_pass++;
      n_checks++; if (data_req !== 1'b1) $display("FAIL reset_data_req: got %b, required 1", data_req); else n_pass++;
      mon_en = 1'b1;
   endtask

   task automatic test_basic(input logic last);
      int st, b0;
      logic [PW-1:0] want;
      packet_data_ready = 1'b1;
      b0 = beats;
      for (int i = 0; i < WORDS; i++) begin
         ahb_write(11'((int'(last) << 10) | (i * 4)), 32'(i), 3'd2, st);
         want[32*i +: 32] = 32'(i);
         n_checks++; if (data_req !== 1'b1) $display("FAIL basic_data_req: word %0d got %b, required 1", i, data_req); else n_pass++;
      end
      repeat (3) step();
      n_checks++; if (beats !== b0 + 1) $display("FAIL basic_beats: got %0d, required %0d", beats - b0, 1); else n_pass++;
      n_checks++; if (last_beat_data !== want) $display("FAIL basic_words: got %h, required %h", last_beat_data, want); else n_pass++;
      n_checks++; if (last_beat_last !== last) $display("FAIL basic_last: got %b, required %b", last_beat_last, last); else n_pass++;
   endtask

   task automatic test_backpressure();
      int st, tot, b0;
      packet_data_ready = 1'b0;
      b0 = beats;
      write_packet(1'b0, st);
      n_checks++; if (data_req !== 1'b1) $display("FAIL bp_req_one: got %b, required 1", data_req); else n_pass++;
      n_checks++; if (packet_data_valid !== 1'b1) $display("FAIL bp_valid_one: got %b, required 1", packet_data_valid); else n_pass++;
      write_packet(1'b1, st);
      n_checks++; if (data_req !== 1'b0) $display("FAIL bp_req_full: got %b, required 0", data_req); else n_pass++;
      tot = 0;
      for (int i = 0; i < WORDS - 1; i++) begin
         ahb_write(11'(i * 4), $urandom, 3'd2, st);
         tot += st;
      end
      n_checks++; if (tot !== 0) $display("FAIL bp_noncomplete_stall: got %0d stalls, required 0", tot); else n_pass++;
      fork
         ahb_write(11'h03C, $urandom, 3'd2, st);
         begin
            repeat (3) step();
            packet_data_ready = 1'b1;
            step();
            packet_data_ready = 1'b0;
         end
      join
      n_checks++; if (st !== 2) $display("FAIL bp_stall_cycles: got %0d, required 2", st); else n_pass++;
      n_checks++; if (data_req !== 1'b0) $display("FAIL bp_req_after: got %b, required 0", data_req); else n_pass++;
      n_checks++; if (exp_q.size() !== 2) $display("FAIL bp_count: got %0d queued, required 2", exp_q.size()); else n_pass++;
      packet_data_ready = 1'b1;
      repeat (6) step();
      n_checks++; if (packet_data_valid !== 1'b0) $display("FAIL bp_drain_valid: got %b, required 0", packet_data_valid); else n_pass++;
      n_checks++; if (beats - b0 !== 3) $display("FAIL bp_beats: got %0d, required 3", beats - b0); else n_pass++;
      n_checks++; if (data_req !== 1'b1) $display("FAIL bp_drain_req: got %b, required 1", data_req); else n_pass++;
   endtask

   task automatic test_bytes();
      int st;
      logic [31:0] d;
      ahb_write(11'h001, 32'h0000AA00, 3'd0, st);
      ahb_write(11'h002, 32'hBEEF0000, 3'd1, st);
      ahb_read(11'h000, d);
      n_checks++; if (d !== 32'hBEEFAA00) $display("FAIL bytes_read: got %h, required %h", d, 32'hBEEFAA00); else n_pass++;
      n_checks++; if (d !== model_word(0)) $display("FAIL bytes_model: got %h, required %h", d, model_word(0)); else n_pass++;
   endtask

   task automatic test_mid_reset();
      int st, b0;
      logic [31:0] d;
      logic [PW-1:0] want;
      packet_data_ready = 1'b1;
      for (int i = 0; i < 8; i++) ahb_write(11'(i * 4), $urandom, 3'd2, st);
      b0 = beats;
      HRESETn = 1'b0;
      step();
      n_checks++; if (packet_data_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", packet_data_valid); else n_pass++;
      n_checks++; if (HREADYOUTS !== 1'b1) $display("FAIL rst_hready: got %b, required 1", HREADYOUTS); else n_pass++;
      step();
      HRESETn = 1'b1;
      model_clear();
      ahb_read(11'h008, d);
      n_checks++; if (d !== 32'h0) $display("FAIL rst_stage_clear: got %h, required 0", d); else n_pass++;
      for (int i = 0; i < WORDS; i++) begin
         want[32*i +: 32] = $urandom;
         ahb_write(11'(i * 4), want[32*i +: 32], 3'd2, st);
      end
      repeat (3) step();
      n_checks++; if (beats - b0 !== 1) $display("FAIL rst_beats: got %0d, required 1", beats - b0); else n_pass++;
      n_checks++; if (last_beat_data !== want) $display("FAIL rst_fresh_data: got %h, required %h", last_beat_data, want); else n_pass++;
   endtask

   task automatic test_random();
      int st, idx, sz, lo, tmp, j;
      int order [WORDS-1];
      logic lst;
      logic [31:0] d;
      rnd_ready = 1'b1;
      for (int p = 0; p < 4; p++) begin
         lst = 1'($urandom_range(0, 1));
         for (int k = 0; k < WORDS - 1; k++) order[k] = k;
         for (int k = WORDS - 2; k > 0; k--) begin
            j = $urandom_range(0, k);
            tmp = order[k]; order[k] = order[j]; order[j] = tmp;
         end
         for (int k = 0; k < WORDS - 1; k++) begin
            idx = order[k];
            sz  = $urandom_range(0, 2);
            lo  = (sz == 2) ? 0 : (sz == 1) ? 2 * $urandom_range(0, 1) : $urandom_range(0, 3);
            ahb_write(11'((int'(lst) << 10) | (idx * 4) | lo), $urandom, 3'(sz), st);
            n_checks++; if (st !== 0) $display("FAIL rnd_stall: word %0d got %0d stalls, required 0", idx, st); else n_pass++;
            if (k % 5 == 4) begin
               ahb_read(11'(idx * 4), d);
               n_checks++; if (d !== model_word(idx)) $display("FAIL rnd_read: idx %0d got %h, required %h", idx, d, model_word(idx)); else n_pass++;
            end
         end
         ahb_write(11'((int'(lst) << 10) | 60), $urandom, 3'd2, st);
      end
      rnd_ready = 1'b0;
      step();
      packet_data_ready = 1'b1;
      repeat (6) step();
      n_checks++; if (exp_q.size() !== 0) $display("FAIL rnd_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
      n_checks++; if (packet_data_valid !== 1'b0) $display("FAIL rnd_valid: got %b, required 0", packet_data_valid); else n_pass++;
   endtask

`ifdef WRAPPER_PKT_STATUS_EN
   task automatic test_status();
      int st;
      logic [31:0] d, want;
      packet_data_ready = 1'b0;
      write_packet(1'b0, st);
      write_packet(1'b0, st);
      for (int i = 0; i < 5; i++) ahb_write(11'(i * 4), $urandom, 3'd2, st);
      want = {16'b0, 8'(exp_q.size()), 8'($countones(m_written))};
      ahb_read(11'h200, d);
      n_checks++; if (d !== 32'h00000205) $display("FAIL status_const: got %h, required %h", d, 32'h00000205); else n_pass++;
      n_checks++; if (d !== want) $display("FAIL status_model: got %h, required %h", d, want); else n_pass++;
      ahb_read(11'h008, d);
      n_checks++; if (d !== model_word(2)) $display("FAIL status_stage: got %h, required %h", d, model_word(2)); else n_pass++;
      packet_data_ready = 1'b1;
      repeat (6) step();
      n_checks++; if (exp_q.size() !== 0) $display("FAIL status_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at 1ms, required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic(1'b0);
      test_basic(1'b1);
      test_backpressure();
      test_bytes();
      test_mid_reset();
      test_random();
`ifdef WRAPPER_PKT_STATUS_EN
      test_status();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
